// File: rtl/sw_link_pkg.sv
// rtl/sw_link_pkg.sv - shared types and line constants for the single-wire link
// Contents: sw_state_t link FSM states, DATA_BITS, LINE_IDLE / START_LVL line levels.
package sw_link_pkg;

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TURN,
      RX_WAIT,
      RX_START,
      RX_DATA,
      RX_STOP,
      DONE
   } sw_state_t;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/sw_half_duplex_master_if.sv
// rtl/sw_half_duplex_master_if.sv - command, response and pad bundle of the link master
// Command: cmd_valid/cmd_ready/cmd_data/cmd_rd. Response: rx_data/rx_valid/done/err_frame/err_timeout/busy.
// Pad (IOBUF): pad_i drive value, pad_t tristate (1 = released), pad_o readback.
// master modport is the link master side; slave modport is the command issuer / pad side.
interface sw_half_duplex_master_if;
   import sw_link_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [DATA_BITS-1:0] cmd_data;
   logic                 cmd_rd;
   logic                 pad_i;
   logic                 pad_t;
   logic                 pad_o;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 done;
   logic                 err_frame;
   logic                 err_timeout;
   logic                 busy;

   modport master (
      input  cmd_valid, cmd_data, cmd_rd, pad_o,
      output cmd_ready, pad_i, pad_t, rx_data, rx_valid, done, err_frame, err_timeout, busy
   );

   modport slave (
      output cmd_valid, cmd_data, cmd_rd, pad_o,
      input  cmd_ready, pad_i, pad_t, rx_data, rx_valid, done, err_frame, err_timeout, busy
   );

endinterface

// File: rtl/sw_bit_timer.sv
// rtl/sw_bit_timer.sv - loadable down-counter with terminal count
// Ports: clk, rst_n (async active-low), load/load_val (restart at load_val), tc (count is zero).
// Loading N-1 gives tc in the Nth cycle after the load; the count holds at zero, never wraps.
module sw_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/sw_half_duplex_master.sv
// rtl/sw_half_duplex_master.sv - single-wire half-duplex link initiator driving an IOBUF
// Ports: clk, rst_n (async active-low), bus (sw_half_duplex_master_if.master):
//   cmd_valid/cmd_ready/cmd_data/cmd_rd command in; pad_i/pad_t/pad_o IOBUF;
//   rx_data/rx_valid received byte; done/err_frame/err_timeout end of command; busy.
// Parameters: CLK_DIV clk cycles per bit (even, >= 4), TA_BITS turnaround bits, TIMEOUT_BITS response wait.
module sw_half_duplex_master
   import sw_link_pkg::*;
#(
   parameter int CLK_DIV      = 16,
   parameter int TA_BITS      = 2,
   parameter int TIMEOUT_BITS = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   sw_half_duplex_master_if.master  bus
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int TW = $clog2(TIMEOUT_BITS * CLK_DIV + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_BITS * CLK_DIV - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    TA_LAST   = 3'(TA_BITS - 1);

   sw_state_t state, next_state;

   logic [1:0]           sync_q;
   logic                 pad_s, pad_s_d, fall;
   logic [DATA_BITS-1:0] tx_byte, rx_shift, rx_data_q;
   logic                 rd_q, rdy_q, rx_valid_q, err_frame_q, err_timeout_q;
   logic                 pad_t_q, pad_i_q;
   logic [2:0]           bit_idx;

   logic                 accept, bt_load, bt_tc, to_load, to_tc;
   logic [BW-1:0]        bt_val;
   logic                 bit_clr, bit_inc, shift_en, stop_en, set_to;

   sw_bit_timer #(.W(BW)) u_bit_tmr (
      .clk(clk), .rst_n(rst_n), .load(bt_load), .load_val(bt_val), .tc(bt_tc)
   );

   // Timeout timer is loaded only on entry from TURN, so a rejected start
   // glitch keeps counting from the original RX_WAIT entry.
   sw_bit_timer #(.W(TW)) u_to_tmr (
      .clk(clk), .rst_n(rst_n), .load(to_load), .load_val(TO_LAST), .tc(to_tc)
   );

   // pad_o is asynchronous; pad_s_d is kept for falling-edge detection so a
   // line already low on RX_WAIT entry is not mistaken for a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= {2{LINE_IDLE}};
         pad_s_d <= LINE_IDLE;
      end else begin
         sync_q  <= {sync_q[0], bus.pad_o};
         pad_s_d <= pad_s;
      end
   end

   assign pad_s = sync_q[1];
   assign fall  = pad_s_d && !pad_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      bt_load    = 1'b0;
      bt_val     = BIT_LAST;
      to_load    = 1'b0;
      bit_clr    = 1'b0;
      bit_inc    = 1'b0;
      shift_en   = 1'b0;
      stop_en    = 1'b0;
      set_to     = 1'b0;
      case (state)
         IDLE: if (bus.cmd_valid && rdy_q) begin
            accept     = 1'b1;
            next_state = TX_START;
            bt_load    = 1'b1;
         end
         TX_START: if (bt_tc) begin
            next_state = TX_DATA;
            bt_load    = 1'b1;
            bit_clr    = 1'b1;
         end
         TX_DATA: if (bt_tc) begin
            bt_load = 1'b1;
            if (bit_idx == DATA_LAST) next_state = TX_STOP;
            else                      bit_inc    = 1'b1;
         end
         TX_STOP: if (bt_tc) begin
            next_state = TURN;
            bt_load    = 1'b1;
            bit_clr    = 1'b1;
         end
         // Turnaround is counted in whole bit periods on the bit index.
         TURN: if (bt_tc) begin
            if (bit_idx == TA_LAST) begin
               if (rd_q) begin
                  next_state = RX_WAIT;
                  to_load    = 1'b1;
               end else begin
                  next_state = DONE;
               end
            end else begin
               bt_load = 1'b1;
               bit_inc = 1'b1;
            end
         end
         RX_WAIT: if (fall) begin
            next_state = RX_START;
            bt_load    = 1'b1;
            bt_val     = HALF_LAST;
         end else if (to_tc) begin
            next_state = DONE;
            set_to     = 1'b1;
         end
         RX_START: if (bt_tc) begin
            if (pad_s == START_LVL) begin
               next_state = RX_DATA;
               bt_load    = 1'b1;
               bit_clr    = 1'b1;
            end else begin
               next_state = RX_WAIT;
            end
         end
         RX_DATA: if (bt_tc) begin
            bt_load  = 1'b1;
            shift_en = 1'b1;
            if (bit_idx == DATA_LAST) next_state = RX_STOP;
            else                      bit_inc    = 1'b1;
         end
         // Stop sample raises rx_valid; DONE follows in the next cycle.
         RX_STOP: begin
            if (rx_valid_q)  next_state = DONE;
            else if (bt_tc)  stop_en    = 1'b1;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_byte       <= '0;
         rd_q          <= 1'b0;
         rx_shift      <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         err_frame_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         bit_idx       <= '0;
         rdy_q         <= 1'b0;
         pad_t_q       <= 1'b1;
         pad_i_q       <= LINE_IDLE;
      end else begin
         rdy_q      <= (next_state == IDLE);
         rx_valid_q <= 1'b0;
         if (accept) begin
            tx_byte <= bus.cmd_data;
            rd_q    <= bus.cmd_rd;
         end
         if (bit_clr)      bit_idx <= '0;
         else if (bit_inc) bit_idx <= bit_idx + 1'b1;
         if (shift_en) rx_shift <= {pad_s, rx_shift[DATA_BITS-1:1]};
         if (stop_en) begin
            rx_data_q   <= rx_shift;
            rx_valid_q  <= 1'b1;
            err_frame_q <= (pad_s != LINE_IDLE);
         end
         if (set_to) err_timeout_q <= 1'b1;
         if (state == DONE) begin
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
         end
         // Pad registers follow the state one cycle late; every segment keeps its full length.
         case (state)
            TX_START: begin pad_t_q <= 1'b0; pad_i_q <= START_LVL;        end
            TX_DATA:  begin pad_t_q <= 1'b0; pad_i_q <= tx_byte[bit_idx]; end
            TX_STOP:  begin pad_t_q <= 1'b0; pad_i_q <= LINE_IDLE;        end
            default:  begin pad_t_q <= 1'b1; pad_i_q <= LINE_IDLE;        end
         endcase
      end
   end

   assign bus.cmd_ready   = rdy_q;
   assign bus.pad_t       = pad_t_q;
   assign bus.pad_i       = pad_i_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.done        = (state == DONE);
   assign bus.err_frame   = err_frame_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.busy        = (state != IDLE);

endmodule
